// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer state encoding and default bus widths.
// Used by both the requester and the completer side.
package apb_pkg;

  localparam int unsigned ApbAddrWidth = 5;
  localparam int unsigned ApbDataWidth = 32;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating count of APB wait states with a timeout strobe.
// fire_o pulses in the wait cycle that would exceed the TIMEOUT budget.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic count_en_i,
  output logic fire_o
);

  if (TIMEOUT == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk_i, rst_i, clear_i, count_en_i};
    assign fire_o        = 1'b0;
  end else begin : g_on
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);
    localparam logic [CntW-1:0] CntFire = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_d, cnt_q;

    always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
        cnt_d = '0;
      end else if (count_en_i && (cnt_q != CntMax)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign fire_o = count_en_i && (cnt_q == CntFire);
  end

endmodule

// File: rtl/apb_master.sv
// APB3 requester: valid/ready command in, SETUP/ACCESS transfer out, one registered
// response pulse per command (completion, completer error, or wait-state timeout).
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ApbAddrWidth,
  parameter int unsigned DATA_WIDTH = ApbDataWidth,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  apb_state_e            state_d, state_q;
  logic [ADDR_WIDTH-1:0] addr_d, addr_q;
  logic                  write_d, write_q;
  logic [DATA_WIDTH-1:0] wdata_d, wdata_q;
  logic                  rsp_valid_d, rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_d, rsp_rdata_q;
  logic                  rsp_slverr_d, rsp_slverr_q;
  logic                  rsp_timeout_d, rsp_timeout_q;

  logic in_access, done, fire, accept;

  assign in_access = (state_q == StAccess);
  assign done      = in_access && PREADY;
  assign cmd_ready = (state_q == StIdle) || (done && !fire);
  assign accept    = cmd_valid && cmd_ready;

  // Every accept leads straight into SETUP, so it doubles as the counter clear.
  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk_i      (PCLK),
    .rst_i      (PRESET),
    .clear_i    (accept),
    .count_en_i (in_access && !PREADY),
    .fire_o     (fire)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    write_d       = write_q;
    wdata_d       = wdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;

    if (accept) begin
      addr_d  = cmd_addr;
      write_d = cmd_write;
      wdata_d = cmd_wdata;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StSetup;
      end
      StSetup: begin
        state_d = StAccess;
      end
      StAccess: begin
        if (fire) begin
          state_d       = StIdle;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_slverr_d  = 1'b1;
          rsp_timeout_d = 1'b1;
        end else if (PREADY) begin
          state_d       = accept ? StSetup : StIdle;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = write_q ? '0 : PRDATA;
          rsp_slverr_d  = PSLVERR;
          rsp_timeout_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      write_q       <= write_d;
      wdata_q       <= wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Bus strobes decode straight from the state register so reset drops them at once.
  assign PSEL        = (state_q != StIdle);
  assign PENABLE     = in_access;
  assign PADDR       = addr_q;
  assign PWRITE      = write_q;
  assign PWDATA      = wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master: a transaction-level schedule model predicts bus
// pins, cmd_ready and responses cycle by cycle; a scripted completer answers transfers.
module tb_apb_master;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int          T  = 4;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_slverr;
  logic          rsp_timeout;
  logic [AW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA = '0;
  logic          PREADY = 1'b0;
  logic          PSLVERR = 1'b0;

  apb_master #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (T)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_slverr  (rsp_slverr),
    .rsp_timeout (rsp_timeout),
    .PADDR       (PADDR),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // One command plus the completer behaviour scripted for it and its bus schedule.
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    int            w;
    bit            tmo;
    int            setup_at;
    int            access_end;
  } txn_t;

  txn_t q[$];
  txn_t pc;
  bit   pend = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic txn_t new_txn(input bit force_tmo);
    txn_t t;
    t.wr    = 1'($urandom);
    t.addr  = AW'($urandom);
    t.wdata = $urandom;
    t.rdata = $urandom;
    t.err   = ($urandom_range(0, 3) == 0);
    if (force_tmo || $urandom_range(0, 5) == 0) t.w = T + int'($urandom_range(0, 2));
    else t.w = int'($urandom_range(0, 2));
    t.tmo        = (t.w >= T);
    t.setup_at   = 0;
    t.access_end = 0;
    return t;
  endfunction

  // Called at a falling edge; checks this cycle, drives next inputs, advances one cycle.
  task automatic step(input bit allow_new);
    txn_t a;
    txn_t r;
    bit   have_a = 1'b0;
    bit   exp_rsp = 1'b0;
    int   free_at = 0;
    int   f;
    foreach (q[i]) begin
      if (q[i].setup_at <= cyc && cyc <= q[i].access_end) begin
        a = q[i];
        have_a = 1'b1;
      end
      if (q[i].access_end + 1 == cyc) begin
        r = q[i];
        exp_rsp = 1'b1;
      end
      // A normal completion frees the port in its last ACCESS cycle; an abort does not.
      f = q[i].tmo ? q[i].access_end + 1 : q[i].access_end;
      if (f > free_at) free_at = f;
    end

    check("psel", 32'(PSEL), 32'(have_a));
    check("penable", 32'(PENABLE), 32'(have_a && cyc > a.setup_at));
    if (have_a) begin
      check("paddr", 32'(PADDR), 32'(a.addr));
      check("pwrite", 32'(PWRITE), 32'(a.wr));
      if (a.wr) check("pwdata", PWDATA, a.wdata);
    end
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    if (exp_rsp) begin
      check("rsp_rdata", rsp_rdata, (r.tmo || r.wr) ? 32'h0 : r.rdata);
      check("rsp_slverr", 32'(rsp_slverr), 32'(r.tmo || r.err));
      check("rsp_timeout", 32'(rsp_timeout), 32'(r.tmo));
    end

    if (have_a && cyc > a.setup_at) begin
      PREADY  = !a.tmo && (cyc == a.access_end);
      PRDATA  = PREADY ? a.rdata : $urandom;
      PSLVERR = PREADY ? a.err : 1'($urandom);
    end else begin
      PREADY  = 1'($urandom);
      PRDATA  = $urandom;
      PSLVERR = 1'($urandom);
    end

    if (!pend && allow_new && $urandom_range(0, 2) != 0) begin
      pc   = new_txn(1'b0);
      pend = 1'b1;
    end
    cmd_valid = pend;
    cmd_write = pend ? pc.wr : 1'($urandom);
    cmd_addr  = pend ? pc.addr : AW'($urandom);
    cmd_wdata = pend ? pc.wdata : $urandom;

    #1;
    check("cmd_ready", 32'(cmd_ready), 32'(cyc >= free_at));
    if (pend && cmd_ready) begin
      pc.setup_at   = cyc + 1;
      pc.access_end = pc.tmo ? cyc + 1 + T : cyc + 2 + pc.w;
      q.push_back(pc);
      pend = 1'b0;
    end
    while (q.size() > 0 && q[0].access_end + 1 <= cyc) void'(q.pop_front());

    @(negedge PCLK);
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (q.size() > 0 || pend); i++) step(1'b0);
    check("drain_done", 32'(q.size() > 0 || pend), 32'h0);
  endtask

  initial begin
    #1;
    check("rst_psel", 32'(PSEL), 32'h0);
    check("rst_penable", 32'(PENABLE), 32'h0);
    check("rst_paddr", 32'(PADDR), 32'h0);
    check("rst_pwdata", PWDATA, 32'h0);
    check("rst_pwrite", 32'(PWRITE), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_flags", 32'({rsp_slverr, rsp_timeout}), 32'h0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h1);

    @(negedge PCLK);
    PRESET = 1'b0;

    for (int i = 0; i < 600; i++) step(1'b1);
    drain();

    // Kill a transfer while it sits in a wait state.
    pc   = new_txn(1'b1);
    pend = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0);
    PREADY    = 1'b0;
    cmd_valid = 1'b0;
    #2;
    PRESET = 1'b1;
    #1;
    check("rst_mid_psel", 32'(PSEL), 32'h0);
    check("rst_mid_penable", 32'(PENABLE), 32'h0);
    check("rst_mid_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_mid_cmd_ready", 32'(cmd_ready), 32'h1);
    q.delete();
    @(negedge PCLK);
    PRESET = 1'b0;
    cyc++;

    pc     = new_txn(1'b0);
    pc.wr  = 1'b1;
    pc.w   = 0;
    pc.tmo = 1'b0;
    pend   = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0);
    for (int i = 0; i < 200; i++) step(1'b1);
    drain();
    for (int i = 0; i < 3; i++) step(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
